// File: rtl/store_packer.sv
// rtl/store_packer.sv - sub-word store packer: read-merge-write of sb/sh, direct write of sw
module store_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;
    localparam logic [1:0] OP_XX = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic        w_accept;
    logic        w_bad;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == IDLE);

    // Illegal opcode, halfword on an odd byte, or word not on a word boundary.
    assign w_bad = (op == OP_XX)
                || ((op == OP_SH) && addr[0])
                || ((op == OP_SW) && (addr[1:0] != 2'b00));

    // State register; reset pulls the machine back to IDLE at once, dropping any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: legal sw goes straight to WRITE, sh/sb go through a read and a capture cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_next = ERR;
                    end else if (op == OP_SW) begin
                        w_next = WRITE;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            READ:    w_next = WAIT;
            WAIT:    w_next = WRITE;
            WRITE:   w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Replace only the addressed byte/halfword lane of the read word (little-endian lanes).
    always_comb begin
        w_merged = mem_rdata;
        if (r_op == OP_SB) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else begin
            if (r_addr[1]) begin
                w_merged[31:16] = r_wdata[15:0];
            end else begin
                w_merged[15:0]  = r_wdata[15:0];
            end
        end
    end

    // Request capture on acceptance and merge capture in WAIT, when the read word is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_merge <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op    <= op;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == WAIT) begin
                r_merge <= w_merged;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign mem_rd_en = (r_state == READ);
    assign mem_wr_en = (r_state == WRITE);
    assign done      = (r_state == WRITE);
    assign err       = (r_state == ERR);
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = (r_op == OP_SW) ? r_wdata : r_merge;

endmodule

// File: tb/tb_store_packer.sv
// tb/tb_store_packer.sv - scoreboard bench for store_packer with reference memory model
module tb_store_packer;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_ERR  = 2;
    localparam int K_DONE = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    store_packer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] tb_mem  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    exp_t mon_e;
    int   mon_kind;
    always @(negedge clk) begin
        if (reset && (mem_rd_en || mem_wr_en || err || done)) begin
            chk("rd_wr_exclusive", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
            chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
            mon_kind = mem_rd_en ? K_RD : (mem_wr_en ? K_WR : (err ? K_ERR : K_DONE));
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", mon_kind, cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("event_kind", mon_kind, mon_e.kind);
                chk("event_cycle", cyc, mon_e.cyc);
                if (mon_kind == K_RD || mon_kind == K_WR) chk("mem_addr", mem_addr, mon_e.a);
                if (mon_kind == K_WR) begin
                    chk("mem_wdata", mem_wdata, mon_e.d);
                    chk("done_with_write", {31'd0, done}, 32'd1);
                end
            end
            if (mem_wr_en) tb_mem[mem_addr] = mem_wdata;
        end
    end

    // Memory responder: read data valid exactly one cycle after mem_rd_en, noise otherwise.
    logic        rsp_seen;
    logic [31:0] rsp_a;
    always begin
        @(negedge clk);
        rsp_seen = mem_rd_en;
        rsp_a    = mem_addr;
        @(posedge clk);
        #1;
        if (rsp_seen && tb_mem.exists(rsp_a)) mem_rdata = tb_mem[rsp_a];
        else mem_rdata = $urandom;
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        tb_mem[a]  = v;
        ref_mem[a] = v;
    endtask

    // Present one request, wait for acceptance, queue what the store rules predict.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                         input bit abort, output int pre);
        int          waited;
        bit          bad;
        exp_t        e;
        logic [31:0] wa;
        logic [31:0] old;
        logic [31:0] mask;
        logic [31:0] nw;
        int          sh;
        @(negedge clk);
        req_valid = 1'b1;
        op        = o;
        addr      = a;
        wdata     = d;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        pre = cyc;
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 at cycle %0d", cyc);
            req_valid = 1'b0;
            return;
        end
        wa  = {a[31:2], 2'b00};
        bad = (o == 2'd3) || (o == 2'd1 && a[0]) || (o == 2'd0 && a[1:0] != 2'd0);
        if (bad) begin
            e = '{K_ERR, pre + 1, 32'd0, 32'd0};
            expq.push_back(e);
        end else if (o == 2'd0) begin
            e = '{K_WR, pre + 1, wa, d};
            expq.push_back(e);
            ref_mem[wa] = d;
        end else begin
            e = '{K_RD, pre + 1, wa, 32'd0};
            expq.push_back(e);
            if (!abort) begin
                old = ref_mem.exists(wa) ? ref_mem[wa] : 32'd0;
                if (o == 2'd2) begin
                    sh   = 8 * int'(a[1:0]);
                    mask = 32'hFF << sh;
                    nw   = (old & ~mask) | ((d & 32'hFF) << sh);
                end else begin
                    sh   = 16 * int'(a[1]);
                    mask = 32'hFFFF << sh;
                    nw   = (old & ~mask) | ((d & 32'hFFFF) << sh);
                end
                e = '{K_WR, pre + 3, wa, nw};
                expq.push_back(e);
                ref_mem[wa] = nw;
            end
        end
        @(posedge clk);
        #1;
        op    = 2'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_mem_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        chk({tag, "_mem_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        int          p;
        int          p1;
        int          p2;
        int          waited;
        int          r;
        logic [1:0]  o;
        reset     = 1'b0;
        req_valid = 1'b0;
        op        = 2'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_rdata = 32'd0;
        for (int i = 0; i < 64; i++) preload(32'h1000 + 32'(4 * i), $urandom);
        preload(32'h2000, 32'h11223344);
        preload(32'h3000, 32'h55667788);

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        issue(2'd0, 32'h1004, 32'hDEADBEEF, 1'b0, p);
        req_valid = 1'b0;
        issue(2'd2, 32'h2002, 32'h000000AB, 1'b0, p);
        req_valid = 1'b0;
        issue(2'd1, 32'h3002, 32'h0000CAFE, 1'b0, p);
        req_valid = 1'b0;
        issue(2'd1, 32'h3001, 32'h12345678, 1'b0, p);
        issue(2'd0, 32'h3002, 32'h9ABCDEF0, 1'b0, p);
        issue(2'd3, 32'h3000, 32'h0F0F0F0F, 1'b0, p);
        req_valid = 1'b0;

        issue(2'd2, 32'h1011, $urandom, 1'b0, p1);
        issue(2'd0, 32'h1014, $urandom, 1'b0, p2);
        chk("b2b_accept_cycle", p2, p1 + 4);
        req_valid = 1'b0;

        issue(2'd2, 32'h1022, $urandom, 1'b1, p);
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            o = (r < 1) ? 2'd3 : (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : 2'd2;
            issue(o, 32'h1000 + $urandom_range(0, 255), $urandom, 1'b0, p);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        req_valid = 1'b0;

        waited = 0;
        while (expq.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", expq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_packer.md
STORE_PACKER -- requirements
Module: store_packer

Interface
REQ-001 SHALL have the port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 SHALL have the port reset, input, 1 bit, an asynchronous active-low reset; reset==0 forces the reset state immediately, regardless of clk.
REQ-003 SHALL have the port req_valid, input, 1 bit, a store request is present.
REQ-004 SHALL have the port req_ready, output, 1 bit, the block can accept a request.
REQ-005 SHALL have the port op, input, 2 bits, the store width: 00 sw, 01 sh, 10 sb, 11 illegal.
REQ-006 SHALL have the port addr, input, 32 bits, the byte address.
REQ-007 SHALL have the port wdata, input, 32 bits, the store data; for sh/sb only the low 16/8 bits are used.
REQ-008 SHALL have the port mem_addr, output, 32 bits, the word-aligned address, equal to {addr_q[31:2],2'b00}.
REQ-009 SHALL have the port mem_rd_en, output, 1 bit, a word-read strobe.
REQ-010 SHALL have the port mem_rdata, input, 32 bits, the read word; it is valid exactly one cycle after mem_rd_en.
REQ-011 SHALL have the port mem_wr_en, output, 1 bit, a word-write strobe.
REQ-012 SHALL have the port mem_wdata, output, 32 bits, the full word to write.
REQ-013 SHALL have the port done, output, 1 bit, a one-cycle pulse on successful completion.
REQ-014 SHALL have the port err, output, 1 bit, a one-cycle pulse on a misaligned or illegal request.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, WRITE, ERR.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid&&req_ready at a rising edge, and op, addr and wdata are registered (op_q, addr_q, wdata_q).
REQ-017 SHALL go from IDLE to ERR on acceptance if op==11, if op==01 with addr[0]==1, or if op==00 with addr[1:0]!=0.
REQ-018 SHALL go from IDLE to WRITE on acceptance of a legal sw, with mem_wdata=wdata_q.
REQ-019 SHALL go from IDLE to READ on acceptance of a legal sh/sb.
REQ-020 SHALL assert mem_rd_en for exactly one cycle in READ, then go to WAIT.
REQ-021 SHALL capture mem_rdata into the merge register in WAIT, then go to WRITE.
REQ-022 SHALL merge little-endian: for sb, byte lane addr_q[1:0] is replaced by wdata_q[7:0]; for sh, halfword lane addr_q[1] is replaced by wdata_q[15:0]; all other bytes keep the read value.
REQ-023 SHALL assert mem_wr_en and done together for exactly one cycle in WRITE, then go to IDLE.
REQ-024 SHALL assert err for one cycle in ERR, with no mem_rd_en or mem_wr_en for that request, then go to IDLE.
REQ-025 SHALL meet this latency, counting the acceptance edge as cycle 0: sw writes in cycle 1; sh/sb read in cycle 1, capture in cycle 2 and write in cycle 3; err in cycle 1.
REQ-026 SHALL accept the next request no earlier than the cycle after the block returns to IDLE, so there is never overlap.
REQ-027 SHALL ignore req_valid outside IDLE, and changes to op, addr or wdata after acceptance.
REQ-028 SHALL never assert mem_rd_en and mem_wr_en in the same cycle, nor done and err in the same cycle.

Reset
REQ-029 SHALL, while reset==0, hold state=IDLE, req_ready=1, mem_rd_en=0, mem_wr_en=0, done=0, err=0, and mem_addr, mem_wdata and all registers at 0.
REQ-030 SHALL, on reset asserted mid-operation (READ, WAIT, WRITE or ERR), abort immediately with no write and no done; after release the block is in IDLE.

Verification
REQ-031 SHALL be verified with: sw, addr=0x1004, wdata=0xDEADBEEF -> cycle 1 mem_wr_en=1, mem_addr=0x1004, mem_wdata=0xDEADBEEF, done=1.
REQ-032 SHALL be verified with: sb, addr=0x2002, wdata=0x000000AB, mem_rdata=0x11223344 -> cycle 1 rd_en at 0x2000; cycle 3 mem_wdata=0x11AB3344, done=1.
REQ-033 SHALL be verified with: sh, addr=0x3002, wdata=0x0000CAFE, mem_rdata=0x55667788 -> cycle 3 mem_wdata=0xCAFE7788.
REQ-034 SHALL be verified with: sh at addr=0x3001, then sw at addr=0x3002, then op=11 -> err=1 in cycle 1 each time, with no memory strobes.
REQ-035 SHALL be verified with: sb accepted, reset driven low in WAIT -> outputs reach their reset values immediately; no mem_wr_en ever; req_ready=1 after release.
REQ-036 SHALL be verified with: back-to-back sb then sw while holding req_valid=1 -> the second request is accepted in the cycle after the first write; no overlap.
